// File: rtl/stage2_root_if.sv
// rtl/stage2_root_if.sv - stage 1 -> stage 2 -> stage 3 job/result bundle for the servo-angle pipeline
interface stage2_root_if;
  logic               start;
  logic [15:0]        L;
  logic [13:0]        M;
  logic signed [14:0] N;
  logic               busy;
  logic [15:0]        L_out;
  logic [13:0]        M_out;
  logic signed [14:0] N_out;
  logic [14:0]        R;
  logic               reach;
  logic               valid;

  modport master (
    output start, L, M, N,
    input  busy, L_out, M_out, N_out, R, reach, valid
  );

  modport slave (
    input  start, L, M, N,
    output busy, L_out, M_out, N_out, R, reach, valid
  );
endinterface

// File: rtl/stage2_root.sv
// rtl/stage2_root.sv - servo pipeline stage 2: R = floor(sqrt(M^2 + N^2)) by restoring root, plus reach flag
module stage2_root #(
  parameter int ITER = 15
) (
  input logic          clock,
  input logic          rst,
  stage2_root_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SQUARE, ROOT, DONE} state_t;

  state_t             state_q;
  logic [15:0]        l_hold_q;
  logic [13:0]        m_hold_q;
  logic signed [14:0] n_hold_q;
  logic [14:0]        n_abs_q;
  logic [29:0]        s_q;
  logic [16:0]        rem_q;
  logic [14:0]        root_q;
  logic [3:0]         cnt_q;
  logic               busy_q;
  logic               valid_q;
  logic               reach_q;
  logic [15:0]        l_out_q;
  logic [13:0]        m_out_q;
  logic signed [14:0] n_out_q;
  logic [14:0]        r_q;

  logic [14:0] n_abs_d;
  logic [18:0] rem_sh;
  logic [18:0] trial;
  logic [16:0] rem_d;
  logic [14:0] root_d;
  logic        reach_d;

  always_comb begin
    // -16384 negates to itself, which read unsigned is the wanted 16384
    n_abs_d = bus.N[14] ? (~bus.N + 15'd1) : bus.N;
    rem_sh  = {rem_q, s_q[29:28]};
    trial   = {2'b00, root_q, 2'b01};
    if (rem_sh >= trial) begin
      rem_d  = 17'(rem_sh - trial);
      root_d = {root_q[13:0], 1'b1};
    end else begin
      rem_d  = rem_sh[16:0];
      root_d = {root_q[13:0], 1'b0};
    end
    reach_d = (l_hold_q <= {1'b0, root_d});
  end

  always_ff @(posedge clock) begin
    if (!rst) begin
      state_q  <= IDLE;
      l_hold_q <= '0;
      m_hold_q <= '0;
      n_hold_q <= '0;
      n_abs_q  <= '0;
      s_q      <= '0;
      rem_q    <= '0;
      root_q   <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      reach_q  <= 1'b0;
      l_out_q  <= '0;
      m_out_q  <= '0;
      n_out_q  <= '0;
      r_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            l_hold_q <= bus.L;
            m_hold_q <= bus.M;
            n_hold_q <= bus.N;
            n_abs_q  <= n_abs_d;
            busy_q   <= 1'b1;
            state_q  <= SQUARE;
          end
        end
        SQUARE: begin
          s_q     <= 30'(m_hold_q) * 30'(m_hold_q) + 30'(n_abs_q) * 30'(n_abs_q);
          rem_q   <= '0;
          root_q  <= '0;
          cnt_q   <= '0;
          state_q <= ROOT;
        end
        ROOT: begin
          s_q    <= {s_q[27:0], 2'b00};
          rem_q  <= rem_d;
          root_q <= root_d;
          cnt_q  <= cnt_q + 4'd1;
          // Results land together with valid so stage 3 sees them in the pulse cycle
          if (cnt_q == 4'(ITER - 1)) begin
            l_out_q <= l_hold_q;
            m_out_q <= m_hold_q;
            n_out_q <= n_hold_q;
            r_q     <= root_d;
            reach_q <= reach_d;
            valid_q <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.valid = valid_q;
  assign bus.reach = reach_q;
  assign bus.L_out = l_out_q;
  assign bus.M_out = m_out_q;
  assign bus.N_out = n_out_q;
  assign bus.R     = r_q;
endmodule

// File: tb/tb_stage2_root.sv
// tb/tb_stage2_root.sv - scoreboard bench for stage2_root
module tb_stage2_root;
  logic clock = 1'b0;
  logic rst = 1'b0;

  stage2_root_if bus();
  stage2_root dut (.clock(clock), .rst(rst), .bus(bus));

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0]        l;
    logic [13:0]        m;
    logic signed [14:0] n;
    logic [14:0]        r;
    logic               reach;
  } exp_t;

  exp_t sb[$];
  int   cmp_count = 0;
  int   err_count = 0;
  int   cyc = 0;
  int   t0 = 0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [14:0] isqrt(input longint s);
    longint lo = 0;
    longint hi = 32768;
    longint mid;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (mid * mid <= s) lo = mid;
      else hi = mid;
    end
    return lo[14:0];
  endfunction

  task automatic send_job(input logic [15:0] l, input logic [13:0] m, input logic signed [14:0] n, input bit push);
    exp_t e;
    bus.L = l;
    bus.M = m;
    bus.N = n;
    bus.start = 1'b1;
    if (push) begin
      e.l = l;
      e.m = m;
      e.n = n;
      e.r = isqrt(longint'(m) * longint'(m) + longint'(n) * longint'(n));
      e.reach = ({1'b0, e.r} >= l);
      sb.push_back(e);
    end
    @(negedge clock);
    bus.start = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_valid(input int bound, output int lat);
    lat = -1;
    for (int k = 0; k < bound; k++) begin
      if (bus.valid === 1'b1) begin
        lat = cyc - t0 + 1;
        break;
      end
      @(negedge clock);
    end
  endtask

  function automatic exp_t pop_exp();
    exp_t e;
    e = '{l: 16'd0, m: 14'd0, n: 15'sd0, r: 15'd0, reach: 1'b0};
    if (sb.size() > 0) e = sb.pop_front();
    return e;
  endfunction

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      rst = 1'b0;
      bus.start = 1'b1;
      bus.L = 16'($urandom);
      bus.M = 14'($urandom);
      bus.N = 15'($urandom);
      @(negedge clock);
      cmp_count++;
      if ({bus.busy, bus.valid, bus.reach, bus.L_out, bus.M_out, bus.N_out, bus.R} !== 63'd0) begin
        err_count++;
        $display("FAIL reset_state cyc%0d: busy=%b valid=%b reach=%b L_out=%0d M_out=%0d N_out=%0d R=%0d, required all 0",
                 i, bus.busy, bus.valid, bus.reach, bus.L_out, bus.M_out, bus.N_out, bus.R);
      end
    end
    bus.start = 1'b0;
    rst = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_basic();
    exp_t e;
    int lat;
    send_job(16'd40, 14'd30, 15'sd40, 1'b1);
    wait_valid(40, lat);
    e = pop_exp();
    cmp_count++; if (lat !== 17) begin err_count++; $display("FAIL basic_latency: got %0d required 17", lat); end
    cmp_count++; if (bus.R !== e.r) begin err_count++; $display("FAIL basic_R: got %0d required %0d", bus.R, e.r); end
    cmp_count++; if (bus.reach !== e.reach) begin err_count++; $display("FAIL basic_reach: got %b required %b", bus.reach, e.reach); end
    cmp_count++; if (bus.L_out !== e.l) begin err_count++; $display("FAIL basic_L_out: got %0d required %0d", bus.L_out, e.l); end
    cmp_count++; if (bus.M_out !== e.m) begin err_count++; $display("FAIL basic_M_out: got %0d required %0d", bus.M_out, e.m); end
    cmp_count++; if (bus.N_out !== e.n) begin err_count++; $display("FAIL basic_N_out: got %0d required %0d", bus.N_out, e.n); end
    cmp_count++; if (bus.busy !== 1'b1) begin err_count++; $display("FAIL basic_busy_at_valid: got %b required 1", bus.busy); end
    @(negedge clock);
    cmp_count++; if ({bus.valid, bus.busy} !== 2'b00) begin err_count++; $display("FAIL basic_after_valid: valid,busy=%b required 00", {bus.valid, bus.busy}); end
  endtask

  task automatic test_unreachable();
    exp_t e;
    int lat;
    send_job(16'd100, 14'd3, -15'sd4, 1'b1);
    wait_valid(40, lat);
    e = pop_exp();
    cmp_count++; if (lat !== 17) begin err_count++; $display("FAIL unreach_latency: got %0d required 17", lat); end
    cmp_count++; if (bus.R !== e.r) begin err_count++; $display("FAIL unreach_R: got %0d required %0d", bus.R, e.r); end
    cmp_count++; if (bus.reach !== e.reach) begin err_count++; $display("FAIL unreach_reach: got %b required %b", bus.reach, e.reach); end
    cmp_count++; if (bus.N_out !== e.n) begin err_count++; $display("FAIL unreach_N_out: got %0d required %0d", bus.N_out, e.n); end
    @(negedge clock);
  endtask

  task automatic test_extremes();
    logic [15:0]        tl[4] = '{16'd0, 16'd0, 16'd65535, 16'd23169};
    logic [13:0]        tm[4] = '{14'd16383, 14'd0, 14'd16383, 14'd16383};
    logic signed [14:0] tn[4] = '{-15'sd16384, 15'sd0, 15'sd16383, -15'sd16384};
    exp_t e;
    int lat;
    for (int i = 0; i < 4; i++) begin
      send_job(tl[i], tm[i], tn[i], 1'b1);
      wait_valid(40, lat);
      e = pop_exp();
      cmp_count++; if (lat !== 17) begin err_count++; $display("FAIL extreme%0d_latency: got %0d required 17", i, lat); end
      cmp_count++; if (bus.R !== e.r) begin err_count++; $display("FAIL extreme%0d_R: got %0d required %0d", i, bus.R, e.r); end
      cmp_count++; if (bus.reach !== e.reach) begin err_count++; $display("FAIL extreme%0d_reach: got %b required %b", i, bus.reach, e.reach); end
      @(negedge clock);
    end
  endtask

  task automatic test_random();
    exp_t e;
    int lat;
    for (int i = 0; i < 6; i++) begin
      send_job(16'($urandom_range(0, 30000)), 14'($urandom), 15'($urandom), 1'b1);
      wait_valid(40, lat);
      e = pop_exp();
      cmp_count++; if (bus.R !== e.r) begin err_count++; $display("FAIL random%0d_R: got %0d required %0d", i, bus.R, e.r); end
      cmp_count++; if (bus.reach !== e.reach) begin err_count++; $display("FAIL random%0d_reach: got %b required %b", i, bus.reach, e.reach); end
      cmp_count++; if (bus.N_out !== e.n) begin err_count++; $display("FAIL random%0d_N_out: got %0d required %0d", i, bus.N_out, e.n); end
      @(negedge clock);
    end
  endtask

  task automatic test_collision();
    exp_t e;
    int n_valid = 0;
    int vcyc = -1;
    int busy_low = 0;
    send_job(16'd10, 14'd6, 15'sd8, 1'b1);
    for (int j = 1; j <= 30; j++) begin
      if (bus.valid === 1'b1) begin
        n_valid++;
        if (vcyc < 0) vcyc = j;
      end
      if (j <= 17 && bus.busy !== 1'b1) busy_low++;
      bus.start = (j == 5);
      if (j == 5) begin
        bus.L = 16'd9999;
        bus.M = 14'd1000;
        bus.N = -15'sd2000;
      end
      @(negedge clock);
    end
    e = pop_exp();
    cmp_count++; if (n_valid !== 1) begin err_count++; $display("FAIL collision_valid_count: got %0d required 1", n_valid); end
    cmp_count++; if (vcyc !== 17) begin err_count++; $display("FAIL collision_valid_cycle: got %0d required 17", vcyc); end
    cmp_count++; if (busy_low !== 0) begin err_count++; $display("FAIL collision_busy: low in %0d cycles, required 0", busy_low); end
    cmp_count++; if (bus.R !== e.r) begin err_count++; $display("FAIL collision_R: got %0d required %0d", bus.R, e.r); end
    cmp_count++; if (bus.L_out !== e.l) begin err_count++; $display("FAIL collision_L_out: got %0d required %0d", bus.L_out, e.l); end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int n_valid = 0;
    int lat;
    send_job(16'd7, 14'd300, 15'sd400, 1'b0);
    for (int j = 1; j <= 30; j++) begin
      rst = (j != 8);
      if (bus.valid === 1'b1) n_valid++;
      @(negedge clock);
    end
    rst = 1'b1;
    cmp_count++; if (n_valid !== 0) begin err_count++; $display("FAIL resetmid_no_valid: got %0d pulses required 0", n_valid); end
    cmp_count++;
    if ({bus.busy, bus.reach, bus.L_out, bus.M_out, bus.N_out, bus.R} !== 62'd0) begin
      err_count++;
      $display("FAIL resetmid_outputs: busy=%b reach=%b L_out=%0d M_out=%0d N_out=%0d R=%0d, required all 0",
               bus.busy, bus.reach, bus.L_out, bus.M_out, bus.N_out, bus.R);
    end
    send_job(16'd500, 14'd300, 15'sd400, 1'b1);
    wait_valid(40, lat);
    e = pop_exp();
    cmp_count++; if (lat !== 17) begin err_count++; $display("FAIL resetmid_fresh_latency: got %0d required 17", lat); end
    cmp_count++; if (bus.R !== e.r) begin err_count++; $display("FAIL resetmid_fresh_R: got %0d required %0d", bus.R, e.r); end
    cmp_count++; if (bus.reach !== e.reach) begin err_count++; $display("FAIL resetmid_fresh_reach: got %b required %b", bus.reach, e.reach); end
    @(negedge clock);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    exp_t eb;
    int lat;
    int v1;
    bus.L = 16'd20;
    bus.M = 14'd12;
    bus.N = -15'sd16;
    bus.start = 1'b1;
    e = '{l: 16'd20, m: 14'd12, n: -15'sd16, r: isqrt(longint'(400)), reach: 1'b1};
    sb.push_back(e);
    @(negedge clock);
    t0 = cyc;
    bus.L = 16'd1234;
    bus.M = 14'd5000;
    bus.N = 15'sd12000;
    eb.l = 16'd1234;
    eb.m = 14'd5000;
    eb.n = 15'sd12000;
    eb.r = isqrt(longint'(5000) * 5000 + longint'(12000) * 12000);
    eb.reach = ({1'b0, eb.r} >= 16'd1234);
    sb.push_back(eb);
    wait_valid(40, lat);
    v1 = cyc;
    e = pop_exp();
    cmp_count++; if (lat !== 17) begin err_count++; $display("FAIL b2b_first_latency: got %0d required 17", lat); end
    cmp_count++; if (bus.R !== e.r) begin err_count++; $display("FAIL b2b_first_R: got %0d required %0d", bus.R, e.r); end
    @(negedge clock);
    cmp_count++; if (bus.valid !== 1'b0) begin err_count++; $display("FAIL b2b_single_pulse: valid=%b required 0", bus.valid); end
    @(negedge clock);
    bus.start = 1'b0;
    cmp_count++; if (bus.busy !== 1'b1) begin err_count++; $display("FAIL b2b_second_accept: busy=%b required 1", bus.busy); end
    wait_valid(40, lat);
    e = pop_exp();
    cmp_count++; if (cyc - v1 !== 18) begin err_count++; $display("FAIL b2b_spacing: got %0d required 18", cyc - v1); end
    cmp_count++; if (bus.R !== e.r) begin err_count++; $display("FAIL b2b_second_R: got %0d required %0d", bus.R, e.r); end
    cmp_count++; if (bus.L_out !== e.l) begin err_count++; $display("FAIL b2b_second_L_out: got %0d required %0d", bus.L_out, e.l); end
    cmp_count++; if (bus.reach !== e.reach) begin err_count++; $display("FAIL b2b_second_reach: got %b required %b", bus.reach, e.reach); end
    @(negedge clock);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.L = '0;
    bus.M = '0;
    bus.N = '0;
    test_reset();
    test_basic();
    test_unreachable();
    test_extremes();
    test_random();
    test_collision();
    test_reset_mid();
    test_back_to_back();
    cmp_count++;
    if (sb.size() !== 0) begin err_count++; $display("FAIL scoreboard_drain: %0d left required 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
    $finish;
  end
endmodule
